// File: rtl/sm_perf_counters_if.sv
// Store/read bus between the CPU data path and the performance counter bank.
// The master drives the store triple and the read address; the slave returns
// registered read data.
interface sm_perf_counters_if;
    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_addr_i;
    logic [31:0] rd_data_o;

    modport master (
        output wr_en_i,
        output wr_addr_i,
        output wr_data_i,
        output rd_addr_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_en_i,
        input  wr_addr_i,
        input  wr_data_i,
        input  rd_addr_i,
        output rd_data_o
    );
endinterface

// File: rtl/sm_perf_counters.sv
// Memory-mapped bank of NUM_CNT performance counters. Each channel counts
// clock cycles or one selected event line, and has a snapshot register,
// a sticky overflow flag and an interrupt mask bit. Reads are registered.
module sm_perf_counters #(
    parameter int unsigned NUM_CNT   = 4,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned NUM_EVT   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                clk,
    input  logic                rst,
    sm_perf_counters_if.slave   bus,
    input  logic [NUM_EVT-1:0]  events_i,
    output logic                irq_o
);

    logic                 gen_q;
    logic                 frz_q;
    logic [NUM_CNT-1:0]   ovf_q;
    logic [NUM_CNT-1:0]   irq_en_q;
    logic [NUM_CNT-1:0]   en_q;
    logic [NUM_CNT-1:0]   mode_q;
    logic [3:0]           sel_q  [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap_q [NUM_CNT];
    logic [31:0]          rd_data_q;

    logic                 wr_hit;
    logic                 rd_hit;
    logic                 wr_ctrl;
    logic                 wr_ovf;
    logic                 wr_irq_en;
    logic                 wr_snap;
    logic                 clear_all;
    logic [NUM_CNT-1:0]   ovf_clr;
    logic [NUM_CNT-1:0]   wr_cfg;
    logic [NUM_CNT-1:0]   wr_cnt;
    logic [NUM_CNT-1:0]   inc;
    logic [NUM_CNT-1:0]   ovf_set;
    logic [31:0]          rd_mux;
    logic [15:0]          evt_pad;
    logic                 unused_bits;

    // Zero-padding to 16 lines makes any SEL at or above NUM_EVT read as idle.
    assign evt_pad     = 16'(events_i);
    assign unused_bits = ^{bus.wr_addr_i[1:0], bus.rd_addr_i[1:0], bus.wr_data_i};

    assign wr_hit    = bus.wr_en_i && (bus.wr_addr_i[31:8] == BASE_ADDR[31:8]);
    assign rd_hit    = (bus.rd_addr_i[31:8] == BASE_ADDR[31:8]);
    assign wr_ctrl   = wr_hit && (bus.wr_addr_i[7:2] == 6'd0);
    assign wr_ovf    = wr_hit && (bus.wr_addr_i[7:2] == 6'd1);
    assign wr_irq_en = wr_hit && (bus.wr_addr_i[7:2] == 6'd2);
    assign wr_snap   = wr_hit && (bus.wr_addr_i[7:2] == 6'd3);
    assign clear_all = wr_ctrl && bus.wr_data_i[1];
    assign ovf_clr   = wr_ovf ? bus.wr_data_i[NUM_CNT-1:0] : '0;

    assign irq_o         = |(ovf_q & irq_en_q);
    assign bus.rd_data_o = rd_data_q;

    // Per-channel write decode, increment qualification and overflow detect.
    always_comb begin
        wr_cfg  = '0;
        wr_cnt  = '0;
        inc     = '0;
        ovf_set = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            wr_cfg[i]  = wr_hit && (bus.wr_addr_i[7:4] == 4'(i + 1)) && (bus.wr_addr_i[3:2] == 2'd0);
            wr_cnt[i]  = wr_hit && (bus.wr_addr_i[7:4] == 4'(i + 1)) && (bus.wr_addr_i[3:2] == 2'd1);
            inc[i]     = gen_q && en_q[i] && (mode_q[i] || evt_pad[sel_q[i]]) && !(frz_q && ovf_q[i]);
            // A CNT write wins over the increment, so it also suppresses the wrap.
            ovf_set[i] = inc[i] && !wr_cnt[i] && (&cnt_q[i]);
        end
    end

    // Read multiplexer; misses and unmapped offsets return zero.
    always_comb begin
        rd_mux = '0;
        if (rd_hit) begin
            case (bus.rd_addr_i[7:2])
                6'd0:    rd_mux = {29'd0, frz_q, 1'b0, gen_q};
                6'd1:    rd_mux = 32'(ovf_q);
                6'd2:    rd_mux = 32'(irq_en_q);
                6'd3:    rd_mux = '0;
                default: begin
                    for (int unsigned i = 0; i < NUM_CNT; i++) begin
                        if (bus.rd_addr_i[7:4] == 4'(i + 1)) begin
                            case (bus.rd_addr_i[3:2])
                                2'd0:    rd_mux = {22'd0, mode_q[i], en_q[i], 4'd0, sel_q[i]};
                                2'd1:    rd_mux = 32'(cnt_q[i]);
                                2'd2:    rd_mux = 32'(snap_q[i]);
                                default: rd_mux = '0;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Register state: reset, then clear-all > CNT write > increment per channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q     <= 1'b0;
            frz_q     <= 1'b0;
            ovf_q     <= '0;
            irq_en_q  <= '0;
            en_q      <= '0;
            mode_q    <= '0;
            rd_data_q <= '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                sel_q[i]  <= '0;
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            rd_data_q <= rd_mux;
            if (wr_ctrl) begin
                gen_q <= bus.wr_data_i[0];
                frz_q <= bus.wr_data_i[2];
            end
            if (wr_irq_en) begin
                irq_en_q <= bus.wr_data_i[NUM_CNT-1:0];
            end
            if (clear_all) begin
                ovf_q <= '0;
            end else begin
                ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
            end
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (wr_cfg[i]) begin
                    sel_q[i]  <= bus.wr_data_i[3:0];
                    en_q[i]   <= bus.wr_data_i[8];
                    mode_q[i] <= bus.wr_data_i[9];
                end
                if (clear_all) begin
                    cnt_q[i]  <= '0;
                    snap_q[i] <= '0;
                end else begin
                    if (wr_snap) begin
                        snap_q[i] <= cnt_q[i];
                    end
                    if (wr_cnt[i]) begin
                        cnt_q[i] <= bus.wr_data_i[CNT_WIDTH-1:0];
                    end else if (inc[i]) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule
